// File: rtl/mmsa_pkg.sv
// Shared types and helpers for the mmsa_param matrix-multiply engine.
// Holds the FSM state type, output-mode codes and the size and width helper functions.
package mmsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } state_e;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_DIAG = 1'b1;

    // log2 of the matrix dimension for a size code, clamped to the largest built size
    function automatic int size_to_lg(input logic [1:0] code, input int max_n);
        int lg;
        int lg_max;
        lg     = int'(code) + 1;
        lg_max = $clog2(max_n);
        return (lg > lg_max) ? lg_max : lg;
    endfunction

    function automatic int size_to_n(input logic [1:0] code, input int max_n);
        return 32'd1 << size_to_lg(code, max_n);
    endfunction

    function automatic int calc_out_w(input int data_w, input int max_n);
        return 2 * data_w + 2 * $clog2(max_n);
    endfunction

endpackage

// File: rtl/mmsa_if.sv
// Operand stream and result stream of the mmsa_param engine.
// The master side is the stream source and checker; the slave side is the engine.
interface mmsa_if #(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 16
);
    import mmsa_pkg::*;

    localparam int OUT_W = calc_out_w(DATA_W, MAX_N);

    logic              in_valid;
    logic [DATA_W-1:0] matrix;
    logic [1:0]        matrix_size;
    logic              out_mode;
    logic              busy;
    logic              out_valid;
    logic [OUT_W-1:0]  out_value;

    modport master (
        output in_valid, matrix, matrix_size, out_mode,
        input  busy, out_valid, out_value
    );

    modport slave (
        input  in_valid, matrix, matrix_size, out_mode,
        output busy, out_valid, out_value
    );

endinterface

// File: rtl/mmsa_mac.sv
// Registered multiply-accumulate with clear-on-first and a result strobe on last.
// MMSA_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module mmsa_mac #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [OUT_W-1:0]  res_o,
    output logic              vld_o
);
    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    prod_s;
    logic [OUT_W-1:0] ext_s;
    logic [OUT_W-1:0] sum_s;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             vld_q, vld_d;

    // Product, extension to result width, and accumulator/result next state
    always_comb begin
`ifdef MMSA_SIGNED_EN
        prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
        ext_s  = {{(OUT_W-PW){prod_s[PW-1]}}, prod_s};
`else
        prod_s = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        ext_s  = {{(OUT_W-PW){1'b0}}, prod_s};
`endif
        sum_s = first_i ? ext_s : (acc_q + ext_s);
        acc_d = acc_q;
        res_d = {OUT_W{1'b0}};
        vld_d = 1'b0;
        if (en_i) begin
            acc_d = sum_s;
            if (last_i) begin
                res_d = sum_s;
                vld_d = 1'b1;
            end else begin
                res_d = {OUT_W{1'b0}};
                vld_d = 1'b0;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= {OUT_W{1'b0}};
            res_q <= {OUT_W{1'b0}};
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign res_o = res_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/mmsa_param.sv
// Streams X then W (row-major) into storage and computes Y = X*W on one MAC,
// emitting the full matrix or the anti-diagonal sums. MMSA_SIGNED_EN selects signed arithmetic.
module mmsa_param
    import mmsa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 16
) (
    input logic   clk,
    input logic   rst_n,
    mmsa_if.slave bus
);
    localparam int OUT_W  = calc_out_w(DATA_W, MAX_N);
    localparam int LG_MAX = $clog2(MAX_N);
    localparam int IW     = LG_MAX + 1;
    localparam int AW     = 2 * LG_MAX;
    localparam int LW     = AW + 1;
    localparam int NE     = MAX_N * MAX_N;

    logic [DATA_W-1:0] x_mem [NE];
    logic [DATA_W-1:0] w_mem [NE];

    state_e        state_q, state_d;
    logic [2:0]    lg_q, lg_d;
    logic [IW-1:0] n_q, n_d;
    logic          mode_q, mode_d;
    logic [LW-1:0] ld_q, ld_d;
    logic [IW-1:0] r_q, r_d;
    logic [IW-1:0] c_q, c_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] d_q, d_d;
    logic          done_q, done_d;
    logic          busy_q;

    logic [LW-1:0] nsq_s;
    logic [LW-1:0] ldw_s;
    logic [IW-1:0] nm1_s;
    logic [IW-1:0] col_s;
    logic [IW-1:0] r_lo_s;
    logic [IW-1:0] r_hi_s;
    logic [IW-1:0] r_lo_nx_s;
    logic [IW-1:0] d_nx_s;
    logic [AW-1:0] xa_s;
    logic [AW-1:0] wa_s;
    logic [AW-1:0] wr_a_s;
    logic          wr_x_s;
    logic          wr_w_s;
    logic          mac_en_s;
    logic          mac_first_s;
    logic          mac_last_s;
    logic [OUT_W-1:0] mac_res_s;
    logic             mac_vld_s;

    // Index arithmetic: in diagonal mode c = d - r and r walks [r_lo, r_hi] of diagonal d
    always_comb begin
        nsq_s     = LW'(1) << {lg_q, 1'b0};
        ldw_s     = ld_q - nsq_s;
        nm1_s     = n_q - IW'(1);
        d_nx_s    = d_q + IW'(1);
        col_s     = (mode_q == MODE_DIAG) ? (d_q - r_q) : c_q;
        r_lo_s    = (d_q > nm1_s) ? (d_q - nm1_s) : {IW{1'b0}};
        r_hi_s    = (d_q < nm1_s) ? d_q : nm1_s;
        r_lo_nx_s = (d_nx_s > nm1_s) ? (d_nx_s - nm1_s) : {IW{1'b0}};
        xa_s      = (AW'(r_q) << lg_q) | AW'(k_q);
        wa_s      = (AW'(k_q) << lg_q) | AW'(col_s);
    end

    // Next-state, storage write strobes and MAC control
    always_comb begin
        state_d     = state_q;
        lg_d        = lg_q;
        n_d         = n_q;
        mode_d      = mode_q;
        ld_d        = ld_q;
        r_d         = r_q;
        c_d         = c_q;
        k_d         = k_q;
        d_d         = d_q;
        done_d      = done_q;
        wr_x_s      = 1'b0;
        wr_w_s      = 1'b0;
        wr_a_s      = {AW{1'b0}};
        mac_en_s    = 1'b0;
        mac_first_s = 1'b0;
        mac_last_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    lg_d    = 3'(size_to_lg(bus.matrix_size, MAX_N));
                    n_d     = IW'(size_to_n(bus.matrix_size, MAX_N));
                    mode_d  = bus.out_mode;
                    ld_d    = LW'(1);
                    wr_x_s  = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    ld_d = ld_q + LW'(1);
                    if (ld_q < nsq_s) begin
                        wr_x_s = 1'b1;
                        wr_a_s = ld_q[AW-1:0];
                    end else begin
                        wr_w_s = 1'b1;
                        wr_a_s = ldw_s[AW-1:0];
                    end
                    if (ld_q == (nsq_s + (nsq_s - LW'(1)))) begin
                        state_d = CALC;
                        r_d     = {IW{1'b0}};
                        c_d     = {IW{1'b0}};
                        k_d     = {IW{1'b0}};
                        d_d     = {IW{1'b0}};
                        done_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    ld_d = ld_q;
                end
            end
            CALC: begin
                // One drain cycle after the last MAC lets its result leave before IDLE
                if (done_q) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    mac_en_s = 1'b1;
                    if (mode_q == MODE_DIAG) begin
                        mac_first_s = (k_q == {IW{1'b0}}) && (r_q == r_lo_s);
                        mac_last_s  = (k_q == nm1_s) && (r_q == r_hi_s);
                    end else begin
                        mac_first_s = (k_q == {IW{1'b0}});
                        mac_last_s  = (k_q == nm1_s);
                    end
                    if (k_q == nm1_s) begin
                        k_d = {IW{1'b0}};
                        if (mode_q == MODE_DIAG) begin
                            if (r_q == r_hi_s) begin
                                d_d    = d_nx_s;
                                r_d    = r_lo_nx_s;
                                done_d = (d_q == (nm1_s + nm1_s));
                            end else begin
                                r_d = r_q + IW'(1);
                            end
                        end else begin
                            if (c_q == nm1_s) begin
                                c_d    = {IW{1'b0}};
                                r_d    = r_q + IW'(1);
                                done_d = (r_q == nm1_s);
                            end else begin
                                c_d = c_q + IW'(1);
                            end
                        end
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lg_q    <= 3'd1;
            n_q     <= IW'(2);
            mode_q  <= MODE_FULL;
            ld_q    <= {LW{1'b0}};
            r_q     <= {IW{1'b0}};
            c_q     <= {IW{1'b0}};
            k_q     <= {IW{1'b0}};
            d_q     <= {IW{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            d_q     <= d_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Operand storage; contents are meaningless until loaded so no reset
    always_ff @(posedge clk) begin
        if (wr_x_s) begin
            x_mem[wr_a_s] <= bus.matrix;
        end
        if (wr_w_s) begin
            w_mem[wr_a_s] <= bus.matrix;
        end
    end

    mmsa_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mac_en_s),
        .first_i (mac_first_s),
        .last_i  (mac_last_s),
        .a_i     (x_mem[xa_s]),
        .b_i     (w_mem[wa_s]),
        .res_o   (mac_res_s),
        .vld_o   (mac_vld_s)
    );

    assign bus.busy      = busy_q;
    assign bus.out_valid = mac_vld_s;
    assign bus.out_value = mac_res_s;

endmodule

// File: tb/tb_mmsa_param.sv
// Scoreboard bench for mmsa_param: expected results and their output cycles are queued
// when a job is loaded and compared as the engine emits them.
module tb_mmsa_param;
    import mmsa_pkg::*;

    localparam int DW = 16;
    localparam int MN = 16;
    localparam int OW = calc_out_w(DW, MN);

    typedef struct {
        logic [OW-1:0] val;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en   = 1'b0;
    bit   busy_chk = 1'b0;

    exp_t          sb [$];
    logic [OW-1:0] ovr [int];
    logic [DW-1:0] xm [256];
    logic [DW-1:0] wm [256];

    mmsa_if #(.DATA_W(DW), .MAX_N(MN)) bus ();

    mmsa_param #(.DATA_W(DW), .MAX_N(MN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] pmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MMSA_SIGNED_EN
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return OW'(p);
`else
        return OW'({16'd0, a} * {16'd0, b});
`endif
    endfunction

    function automatic logic [OW-1:0] dot(input int n, input int r, input int c);
        logic [OW-1:0] s;
        s = '0;
        for (int k = 0; k < n; k++) s += pmul(xm[r*n+k], wm[k*n+c]);
        return s;
    endfunction

    task automatic push_exp(input logic [OW-1:0] v, input int oi, input int ecyc);
        exp_t e;
        e.val = ovr.exists(oi) ? ovr[oi] : v;
        e.cyc = ecyc;
        sb.push_back(e);
    endtask

    // Loads X then W with optional random gaps, then queues the model's expectations
    task automatic drive_job(input logic [1:0] code, input logic mode, input int gap_pct);
        int n, idx, last_cyc, e;
        logic [OW-1:0] s;
        n = 32'd2 << code;
        idx = 0;
        last_cyc = 0;
        while (idx < 2*n*n) begin
            @(negedge clk);
            if (int'($urandom_range(99, 0)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.matrix   = 16'($urandom);
            end else begin
                bus.in_valid    = 1'b1;
                bus.matrix      = (idx < n*n) ? xm[idx] : wm[idx-n*n];
                bus.matrix_size = (idx == 0) ? code : 2'($urandom_range(3, 0));
                bus.out_mode    = (idx == 0) ? mode : 1'($urandom_range(1, 0));
                last_cyc = cyc;
                idx++;
            end
        end
        e = 0;
        if (mode == MODE_FULL) begin
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    e++;
                    push_exp(dot(n, r, c), e - 1, last_cyc + e*n + 1);
                end
            end
        end else begin
            for (int d = 0; d <= 2*n-2; d++) begin
                s = '0;
                for (int r = 0; r < n; r++) begin
                    if (d - r >= 0 && d - r < n) begin
                        s += dot(n, r, d - r);
                        e++;
                    end
                end
                push_exp(s, d, last_cyc + e*n + 1);
            end
        end
        ovr.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_job(input bit noise);
        for (int t = 0; t < 6000 && sb.size() > 0; t++) begin
            @(negedge clk);
            if (noise) begin
                bus.in_valid = (sb.size() > 1) ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.matrix   = 16'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        if (sb.size() > 0) begin
            chk_val("timeout_left", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n*n; i++) begin
            xm[i] = 16'($urandom);
            wm[i] = 16'($urandom);
        end
    endtask

    // Output monitor: pops the scoreboard on every result beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy_chk) begin
                    chk_val("busy_drop", 64'(bus.busy), 64'd0);
                    busy_chk = 1'b0;
                end
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        chk_val("spurious_out", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk_val("y_val", 64'(bus.out_value), 64'(e.val));
                        chk_val("y_cycle", 64'(cyc), 64'(e.cyc));
                        if (sb.size() == 0) begin
                            chk_val("busy_last", 64'(bus.busy), 64'd1);
                            busy_chk = 1'b1;
                        end
                    end
                end else begin
                    chk_val("out_zero", 64'(bus.out_value), 64'd0);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.matrix      = 16'd0;
        bus.matrix_size = 2'd0;
        bus.out_mode    = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_busy", 64'(bus.busy), 64'd0);
        chk_val("rst_valid", 64'(bus.out_valid), 64'd0);
        chk_val("rst_value", 64'(bus.out_value), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            xm[i] = 16'(i + 1);
            wm[i] = 16'(i + 5);
        end
        ovr[0] = 40'd19; ovr[1] = 40'd22; ovr[2] = 40'd43; ovr[3] = 40'd50;
        drive_job(2'd0, MODE_FULL, 0);
        wait_job(1'b0);
        ovr[0] = 40'd19; ovr[1] = 40'd65; ovr[2] = 40'd50;
        drive_job(2'd0, MODE_DIAG, 0);
        wait_job(1'b0);

`ifdef MMSA_SIGNED_EN
        for (int i = 0; i < 16; i++) begin
            xm[i]  = ((i / 4) == (i % 4)) ? 16'hFFFF : 16'h0000;
            wm[i]  = 16'(i);
            ovr[i] = 40'(-longint'(i));
        end
        drive_job(2'd1, MODE_FULL, 0);
        wait_job(1'b0);
        for (int i = 0; i < 16; i++) begin
            xm[i]  = 16'h8000;
            wm[i]  = 16'h8000;
            ovr[i] = 40'h01_0000_0000;
        end
        drive_job(2'd1, MODE_FULL, 0);
        wait_job(1'b0);
`else
        for (int i = 0; i < 256; i++) begin
            xm[i] = 16'hFFFF;
            wm[i] = 16'hFFFF;
        end
        ovr[0]  = 40'd68717379600;
        ovr[15] = 40'd1099478073600;
        drive_job(2'd3, MODE_DIAG, 0);
        wait_job(1'b0);
`endif

        fill_rand(8);
        drive_job(2'd2, MODE_FULL, 30);
        wait_job(1'b1);
        fill_rand(8);
        drive_job(2'd2, MODE_DIAG, 40);
        wait_job(1'b1);

        // Abort a job mid-calculation, then confirm a fresh job still works
        fill_rand(4);
        drive_job(2'd1, MODE_FULL, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        busy_chk = 1'b0;
        @(negedge clk);
        chk_val("abort_valid", 64'(bus.out_valid), 64'd0);
        chk_val("abort_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        fill_rand(2);
        drive_job(2'd0, MODE_FULL, 0);
        wait_job(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
